// File: rtl/paridade_pkg.sv
// paridade_pkg: shared types and constants for the 6-bit parity path
// Contents: receiver FSM state enum, data/word widths, frame bit order.
package paridade_pkg;
   typedef enum logic [1:0] {OCIOSO, DADOS, PARIDADE, PARADA} estado_t;
   localparam int LARG_DADOS = 5;
   localparam int LARG_PALAVRA = 6;
   localparam logic NIVEL_INICIO = 1'b0;
   localparam logic NIVEL_PARADA = 1'b1;
   localparam int POS_PARIDADE = LARG_DADOS;
   localparam logic [2:0] IDX_ULTIMO = 3'(LARG_DADOS - 1);
endpackage

// File: rtl/calc_paridade.sv
// calc_paridade: combinational even-parity check of a 5-bit data field
// Ports: dados (data bits), par (received parity bit), ok (par matches XOR of dados).
module calc_paridade
   import paridade_pkg::*;
(
   input  logic [LARG_DADOS-1:0] dados,
   input  logic                  par,
   output logic                  ok
);
   assign ok = (par == ^dados);
endmodule

// File: rtl/receptor_serial_paridade.sv
// receptor_serial_paridade: serial frame receiver with parity flag, one-entry output buffer and error counter
// Ports: clk, rst_n (sync active-low), bit_en (bit strobe), rx (serial line, idle 1),
//        palavra/paridade_ok/saida_valida/saida_pronta (valid/ready output),
//        erro_quadro (stop-bit error pulse), estouro (dropped-frame pulse),
//        cont_erros (saturating count of parity, frame and overflow errors).
module receptor_serial_paridade
   import paridade_pkg::*;
#(
   parameter int LARGURA_CONT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bit_en,
   input  logic                    rx,
   output logic [LARG_PALAVRA-1:0] palavra,
   output logic                    paridade_ok,
   output logic                    saida_valida,
   input  logic                    saida_pronta,
   output logic                    erro_quadro,
   output logic                    estouro,
   output logic [LARGURA_CONT-1:0] cont_erros
);
   estado_t estado, estado_prox;
   logic [2:0] idx, idx_prox;
   logic [LARG_PALAVRA-1:0] quadro, quadro_prox;
   logic fim_bom, fim_erro, ok_novo, carrega, transborda, conta;
   calc_paridade u_calc (
      .dados(quadro[LARG_DADOS-1:0]),
      .par  (quadro[POS_PARIDADE]),
      .ok   (ok_novo)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado <= OCIOSO;
         idx    <= '0;
         quadro <= '0;
      end else begin
         estado <= estado_prox;
         idx    <= idx_prox;
         quadro <= quadro_prox;
      end
   end
   always_comb begin
      estado_prox = estado;
      idx_prox    = idx;
      quadro_prox = quadro;
      fim_bom     = 1'b0;
      fim_erro    = 1'b0;
      if (bit_en) begin
         case (estado)
            OCIOSO: begin
               estado_prox = (rx == NIVEL_INICIO) ? DADOS : OCIOSO;
               idx_prox    = '0;
            end
            DADOS: begin
               quadro_prox[idx] = rx;
               estado_prox = (idx == IDX_ULTIMO) ? PARIDADE : DADOS;
               idx_prox    = (idx == IDX_ULTIMO) ? idx : idx + 3'd1;
            end
            PARIDADE: begin
               quadro_prox[POS_PARIDADE] = rx;
               estado_prox = PARADA;
            end
            default: begin
               estado_prox = OCIOSO;
               fim_bom     = (rx == NIVEL_PARADA);
               fim_erro    = (rx != NIVEL_PARADA);
            end
         endcase
      end
   end
   // A finished frame loads when the buffer is free or is being drained this same cycle.
   assign carrega    = fim_bom & (~saida_valida | saida_pronta);
   assign transborda = fim_bom & saida_valida & ~saida_pronta;
   assign conta      = (carrega & ~ok_novo) | fim_erro | transborda;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         palavra      <= '0;
         paridade_ok  <= 1'b0;
         saida_valida <= 1'b0;
         erro_quadro  <= 1'b0;
         estouro      <= 1'b0;
         cont_erros   <= '0;
      end else begin
         palavra      <= carrega ? quadro : palavra;
         paridade_ok  <= carrega ? ok_novo : paridade_ok;
         saida_valida <= carrega | (saida_valida & ~saida_pronta);
         erro_quadro  <= fim_erro;
         estouro      <= transborda;
         if (conta && cont_erros != '1) cont_erros <= cont_erros + LARGURA_CONT'(1);
      end
   end
endmodule

// File: tb/tb_receptor_serial_paridade.sv
// tb_receptor_serial_paridade: table-driven and scoreboard bench for the serial parity receiver
module tb_receptor_serial_paridade;
   logic clk = 1'b0, rst_n = 1'b0, bit_en = 1'b0, rx = 1'b1, saida_pronta = 1'b0;
   logic [5:0] palavra;
   logic paridade_ok, saida_valida, erro_quadro, estouro;
   logic [1:0] cont_erros;
   int n_total = 0, n_bad = 0;
   logic [6:0] fila[$];
   logic [6:0] esp;
   typedef struct {
      logic [4:0] dados;
      logic       par;
      logic       parada;
      logic       exp_ok;
      int         exp_cont;
   } vet_t;
   vet_t tab[7];
   receptor_serial_paridade #(.LARGURA_CONT(2)) dut (
      .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx),
      .palavra(palavra), .paridade_ok(paridade_ok), .saida_valida(saida_valida),
      .saida_pronta(saida_pronta), .erro_quadro(erro_quadro), .estouro(estouro),
      .cont_erros(cont_erros)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   // Scoreboard: every accepted word is compared with the oldest expected entry.
   always @(negedge clk) begin
      #2;
      if (rst_n && saida_valida && saida_pronta) begin
         if (fila.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_inesperado: got palavra=%b expected none", palavra);
         end else begin
            esp = fila.pop_front();
            chk("sb_palavra", int'(palavra), int'(esp[5:0]));
            chk("sb_paridade_ok", int'(paridade_ok), int'(esp[6]));
         end
      end
   end
   task automatic send_bit(input logic b);
      @(negedge clk);
      rx = b;
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      rx = 1'b1;
   endtask
   task automatic send_frame(input logic [4:0] d, input logic p, input logic s);
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      tab[0] = '{5'b10110, 1'b1, 1'b1, 1'b1, 0};
      tab[1] = '{5'b00011, 1'b1, 1'b1, 1'b0, 1};
      tab[2] = '{5'b11111, 1'b1, 1'b1, 1'b1, 1};
      tab[3] = '{5'b00000, 1'b0, 1'b1, 1'b1, 1};
      tab[4] = '{5'b10101, 1'b0, 1'b1, 1'b0, 2};
      tab[5] = '{5'b01100, 1'b1, 1'b0, 1'b0, 3};
      tab[6] = '{5'b00001, 1'b0, 1'b1, 1'b0, 3};
      repeat (3) @(negedge clk);
      chk("rst_palavra", int'(palavra), 0);
      chk("rst_paridade_ok", int'(paridade_ok), 0);
      chk("rst_valida", int'(saida_valida), 0);
      chk("rst_erro_quadro", int'(erro_quadro), 0);
      chk("rst_estouro", int'(estouro), 0);
      chk("rst_cont", int'(cont_erros), 0);
      rst_n = 1'b1;
      saida_pronta = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (tab[i].parada) fila.push_back({tab[i].exp_ok, tab[i].par, tab[i].dados});
         send_frame(tab[i].dados, tab[i].par, tab[i].parada);
         chk("tab_erro_quadro", int'(erro_quadro), int'(!tab[i].parada));
         chk("tab_estouro", int'(estouro), 0);
         chk("tab_cont", int'(cont_erros), tab[i].exp_cont);
         if (!tab[i].parada) chk("tab_valida_sem_quadro", int'(saida_valida), 0);
      end
      repeat (2) @(negedge clk);
      chk("tab_fila_vazia", fila.size(), 0);
      do_reset();
      saida_pronta = 1'b0;
      fila.push_back(7'b1100001);
      send_frame(5'b00001, 1'b1, 1'b1);
      chk("ovf_valida", int'(saida_valida), 1);
      chk("ovf_palavra1", int'(palavra), 6'b100001);
      chk("ovf_estouro0", int'(estouro), 0);
      send_frame(5'b11111, 1'b1, 1'b1);
      chk("ovf_estouro1", int'(estouro), 1);
      chk("ovf_palavra_mantida", int'(palavra), 6'b100001);
      chk("ovf_cont", int'(cont_erros), 1);
      @(negedge clk);
      chk("ovf_estouro_pulso", int'(estouro), 0);
      saida_pronta = 1'b1;
      @(negedge clk);
      chk("ovf_valida_limpa", int'(saida_valida), 0);
      chk("ovf_fila_vazia", fila.size(), 0);
      saida_pronta = 1'b0;
      fila.push_back(7'b1100111);
      send_frame(5'b00111, 1'b1, 1'b1);
      fila.push_back(7'b1001010);
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b1 : 1'b0);
      send_bit(1'b0);
      @(negedge clk);
      rx = 1'b1;
      bit_en = 1'b1;
      saida_pronta = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      chk("sim_estouro", int'(estouro), 0);
      chk("sim_valida", int'(saida_valida), 1);
      chk("sim_palavra", int'(palavra), 6'b001010);
      chk("sim_cont", int'(cont_erros), 1);
      @(negedge clk);
      chk("sim_valida_limpa", int'(saida_valida), 0);
      chk("sim_fila_vazia", fila.size(), 0);
      do_reset();
      for (int k = 0; k < 5; k++) begin
         send_frame(5'b10101, 1'b1, 1'b0);
         chk("sat_erro_quadro", int'(erro_quadro), 1);
         chk("sat_cont", int'(cont_erros), (k + 1 > 3) ? 3 : k + 1);
         @(negedge clk);
         chk("sat_erro_quadro_pulso", int'(erro_quadro), 0);
      end
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_palavra", int'(palavra), 0);
      chk("mid_rst_paridade_ok", int'(paridade_ok), 0);
      chk("mid_rst_valida", int'(saida_valida), 0);
      chk("mid_rst_erro_quadro", int'(erro_quadro), 0);
      chk("mid_rst_estouro", int'(estouro), 0);
      chk("mid_rst_cont", int'(cont_erros), 0);
      rst_n = 1'b1;
      fila.push_back(7'b1111001);
      send_frame(5'b11001, 1'b1, 1'b1);
      chk("pos_rst_erro_quadro", int'(erro_quadro), 0);
      chk("pos_rst_cont", int'(cont_erros), 0);
      repeat (2) @(negedge clk);
      chk("pos_rst_fila_vazia", fila.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/receptor_serial_paridade.md
# receptor_serial_paridade

Serial front end for the 6-bit parity path. Receives one framed word (start bit, 5 data bits LSB first, parity bit, stop bit) on a single serial line, sampled on a bit-rate strobe. It reassembles the 6-bit word `{parity, data[4:0]}`, the same format the parity-verification stage consumes, and flags parity validity alongside it. The word is presented through a one-entry valid/ready output buffer, and parity and framing errors are counted.

## Interface
Parameters:
- `LARGURA_CONT`, 8: width of the saturating error counter.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `bit_en`  in  1  bit-period strobe; `rx` is sampled only on cycles where `bit_en`=1.
- `rx`  in  1  serial line; idle level 1.
- `palavra`  out  6  received word: bit5 = parity bit, bits4:0 = data.
- `paridade_ok`  out  1  1 when `palavra[5]` equals the count of ones in `palavra[4:0]` mod 2. Qualified by `saida_valida`.
- `saida_valida`  out  1  `palavra` and `paridade_ok` hold a word.
- `saida_pronta`  in  1  consumer accepts the word when `saida_valida`=1 and `saida_pronta`=1.
- `erro_quadro`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `estouro`  out  1  one-cycle pulse when a good frame is dropped because the buffer is full.
- `cont_erros`  out  LARGURA_CONT  saturating count of parity errors, frame errors and overflows.

## Operation
- FSM states: OCIOSO, DADOS, PARIDADE, PARADA. All transitions occur only on `bit_en` cycles.
- OCIOSO:
  - `rx`=0 on a strobe → DADOS, and the bit index is cleared.
  - `rx`=1 → remain in OCIOSO.
- DADOS:
  - On each strobe, the sampled `rx` is written to data bit [index], so the first data bit goes to bit0.
  - After the 5th data bit (index 4) → PARIDADE.
- PARIDADE: the strobe captures the parity bit → PARADA.
- PARADA, on the next strobe, always → OCIOSO:
  - `rx`=1: the frame is good and is offered to the output buffer.
  - `rx`=0: the frame is discarded and `erro_quadro` pulses.
- Output buffer:
  - Empty, or full with `saida_pronta`=1 in the same cycle: load `palavra`, compute `paridade_ok`, set `saida_valida`.
  - Full and not accepted in that cycle: keep the old word, drop the new one, and pulse `estouro`.
- `saida_valida` clears on an accept cycle unless a new word loads in that same cycle.
- `cont_erros` increments by 1 for each of the following, in any cycle where it occurs:
  - a loaded word with `paridade_ok`=0;
  - an `erro_quadro` pulse;
  - an `estouro` pulse.
- The three counter events are mutually exclusive per cycle.
- The counter saturates at 2^LARGURA_CONT−1 and does not wrap.
- `paridade_ok` is the XOR of data bits 4:0 compared against bit5.
- A dropped or framing-error frame does not touch the parity check or `palavra`.
- `bit_en`=0 freezes the FSM and the shift register. The output handshake still operates on every clock.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state OCIOSO and the bit index is 0;
  - `palavra`=6'b000000, `paridade_ok`=0 and `saida_valida`=0;
  - `erro_quadro`=0, `estouro`=0 and `cont_erros`=0.
- Reset mid-frame aborts the frame with no error counted.
- Latency: `saida_valida` rises on the clock edge that samples the stop-bit strobe, so it is visible the cycle after that strobe.
- `erro_quadro` and `estouro` are registered. Each is high exactly the one cycle after the stop-bit strobe.
- Handshake:
  - Once `saida_valida`=1, `palavra` is stable until the accept cycle.
  - A consumer holding `saida_pronta`=1 permanently sustains one word per frame.
- Back-to-back frames need no idle bits: a start bit may be sampled on the strobe immediately after the stop bit.

## Structure
- Shared package `paridade_pkg` holds:
  - the FSM state enum;
  - `LARG_DADOS`=5 and `LARG_PALAVRA`=6;
  - the frame bit order constants.
- The parity compare is a natural sub-module, `calc_paridade`, which is combinational with 5-bit data plus a parity bit in and `ok` out. The downstream verification stage can reuse it.
- FSM, shift register, output buffer and counter stay in the top module.

## Test plan
- Good frame, parity correct: data 5'b10110 sent as 0,1,1,0,1, then parity 1, stop 1 → `palavra`=6'b110110, `paridade_ok`=1, `cont_erros`=0.
- Parity error: data 5'b00011 with parity 1 → `palavra`=6'b100011, `paridade_ok`=0, `cont_erros`=1.
- Framing error: any frame with stop bit 0 → `erro_quadro` pulses once, `saida_valida` stays 0, `cont_erros` increments.
- Overflow: `saida_pronta`=0 and two good frames, first data 5'b00001, second 5'b11111 → first word held, `estouro` pulse, `palavra`=6'b100001 retained; accept then clears `saida_valida`.
- Simultaneous accept and load:
  - Stimulus: `saida_pronta` rises in the very cycle the second frame completes.
  - Required: no `estouro`; the second word replaces the first with no gap in `saida_valida`.
- Saturation and reset: with LARGURA_CONT=2, five framing errors → `cont_erros`=3. Then assert `rst_n`=0 mid-frame → all outputs at their reset values, and the next frame is received correctly.
